axi4_lite_slave_regfile: RTL

//  AXI4-Lite slave terminating the bus driven by the AXI4_Lite_Master block.

---
 rtl/axi4_lite_pkg.sv | 34 +++
 rtl/axi4_lite_regbank.sv | 48 ++++
 rtl/axi4_lite_slave_regfile.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register file slave.
// Response codes, channel FSM states and bus widths.
package axi4_lite_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } write_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } read_state_e;

  // Word index falls inside the implemented bank
  function automatic logic addr_hit(
    input logic [29:0] idx,
    input int unsigned n
  );
    return {2'b00, idx} < n;
  endfunction

endpackage

// File: rtl/axi4_lite_regbank.sv
// Register storage with a byte-strobed write port.
// Slot 0 always reads the constant ID value.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001,
  parameter int          IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [STRB_W-1:0]          wstrb,
  input  logic [IDX_W-1:0]           ridx,
  output logic [DATA_W-1:0]          rdata,
  output logic [DATA_W*NUM_REGS-1:0] reg_out
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Strobed byte writes; slot 0 is never written by the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = (ridx == '0) ? ID_VALUE : mem[ridx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    if (g == 0) begin : g_id
      assign reg_out[0 +: DATA_W] = ID_VALUE;
    end else begin : g_reg
      assign reg_out[DATA_W*g +: DATA_W] = mem[g];
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave in front of a register bank.
// Independent write (AW/W/B) and read (AR/R) channel FSMs.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                S_AXI_AWADDR,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [31:0]                S_AXI_WDATA,
  input  logic [3:0]                 S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [31:0]                S_AXI_ARADDR,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [31:0]                S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]     reg_out
);

  localparam int IDX_W = $clog2(NUM_REGS);

  write_state_e      wstate;
  logic              aw_held;
  logic              w_held;
  logic [29:0]       aw_idx;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              awready;
  logic              wready;
  logic              bvalid;
  axi_resp_e         bresp;

  read_state_e       rstate;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  axi_resp_e         rresp;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              w_hit;
  logic              w_ok;
  logic              bank_we;
  logic              r_hit;
  logic [DATA_W-1:0] bank_rdata;
  logic              unused_addr_lsb;

  assign aw_hs   = S_AXI_AWVALID & awready;
  assign w_hs    = S_AXI_WVALID & wready;
  assign ar_hs   = S_AXI_ARVALID & arready;

  assign w_hit   = addr_hit(aw_idx, NUM_REGS);
  assign w_ok    = w_hit && (aw_idx != '0);
  assign bank_we = (wstate == W_EXEC) && w_ok;
  assign r_hit   = addr_hit(S_AXI_ARADDR[31:2], NUM_REGS);

  // Byte lane inside a word carries no meaning here
  assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write channel: collect AW and W in any order, commit, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate  <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            aw_idx  <= S_AXI_AWADDR[31:2];
            aw_held <= 1'b1;
            awready <= 1'b0;
          end else if (!aw_held) begin
            awready <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
            w_held  <= 1'b1;
            wready  <= 1'b0;
          end else if (!w_held) begin
            wready  <= 1'b1;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            wstate <= W_EXEC;
          end
        end
        W_EXEC: begin
          bresp   <= w_ok ? OKAY : SLVERR;
          bvalid  <= 1'b1;
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          wstate  <= W_RESP;
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel: sample bank at AR handshake, hold until RREADY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= r_hit ? bank_rdata : '0;
            rresp   <= r_hit ? OKAY : SLVERR;
            rvalid  <= 1'b1;
            arready <= 1'b0;
            rstate  <= R_RESP;
          end else begin
            arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  axi4_lite_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bank_we),
    .widx    (aw_idx[IDX_W-1:0]),
    .wdata   (wdata_q),
    .wstrb   (wstrb_q),
    .ridx    (S_AXI_ARADDR[IDX_W+1:2]),
    .rdata   (bank_rdata),
    .reg_out (reg_out)
  );

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

endmodule
